control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 160 ++++++++++++++++
 tb/tb_control_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle accumulator control unit: FETCH -> DECODE -> EXECUTE per instruction, with HALT.
// Optional CONTROL_UNIT_SINGLE_STEP_EN adds step_i and a WAIT state after each EXECUTE.
module control_unit #(
  parameter int ALU_BIT_WIDTH        = 4,
  parameter int OPERATION_CODE_WIDTH = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
  input  logic                            step_i,
`endif
  output logic [ALU_BIT_WIDTH-1:0]        instr_addr_o,
  input  logic [7:0]                      instr_data_i,
  output logic [ALU_BIT_WIDTH-1:0]        alu_a_o,
  output logic [ALU_BIT_WIDTH-1:0]        alu_b_o,
  output logic [OPERATION_CODE_WIDTH-1:0] alu_oc_o,
  input  logic [ALU_BIT_WIDTH-1:0]        alu_result_i,
  input  logic                            alu_carry_i,
  output logic [ALU_BIT_WIDTH-1:0]        acc_o,
  output logic                            carry_o,
  output logic                            halt_o,
  output logic [ALU_BIT_WIDTH-1:0]        out_o,
  output logic                            out_valid_o
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALT,
    S_WAIT
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_XORI = 4'h4;
  localparam logic [3:0] OP_ANDI = 4'h5;
  localparam logic [3:0] OP_ORI  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'hA;
  localparam logic [3:0] OP_HLT  = 4'hF;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [ALU_BIT_WIDTH-1:0]   r_pc;
  logic [ALU_BIT_WIDTH-1:0]   w_pc_next;
  logic [7:0]                 r_ir;
  logic [ALU_BIT_WIDTH-1:0]   r_acc;
  logic [ALU_BIT_WIDTH-1:0]   w_acc_next;
  logic                       r_carry;
  logic                       w_carry_next;
  logic [ALU_BIT_WIDTH-1:0]   r_out;
  logic                       r_out_valid;
  logic                       w_out_load;
  logic [ALU_BIT_WIDTH-1:0]   w_imm;
  logic [3:0]                 w_opcode;
  logic [OPERATION_CODE_WIDTH-1:0] w_oc;

  assign w_opcode = r_ir[7:4];

  always_comb begin
    w_imm      = '0;
    w_imm[3:0] = r_ir[3:0];
  end

  // Next-state, PC and datapath writes are only non-trivial in EXECUTE.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_acc_next   = r_acc;
    w_carry_next = r_carry;
    w_out_load   = 1'b0;
    w_oc         = '0;
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: w_state_next = S_EXECUTE;
      S_EXECUTE: begin
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
        w_state_next = S_WAIT;
`else
        w_state_next = S_FETCH;
`endif
        w_pc_next = r_pc + ALU_BIT_WIDTH'(1);
        case (w_opcode)
          OP_LDI:  w_acc_next = w_imm;
          OP_ADDI: begin
            w_oc         = OPERATION_CODE_WIDTH'(3'b100);
            w_acc_next   = alu_result_i;
            w_carry_next = alu_carry_i;
          end
          OP_SUBI: begin
            w_oc         = OPERATION_CODE_WIDTH'(3'b110);
            w_acc_next   = alu_result_i;
            w_carry_next = alu_carry_i;
          end
          OP_XORI: begin
            w_oc       = OPERATION_CODE_WIDTH'(3'b001);
            w_acc_next = alu_result_i;
          end
          OP_ANDI: begin
            w_oc       = OPERATION_CODE_WIDTH'(3'b010);
            w_acc_next = alu_result_i;
          end
          OP_ORI: begin
            w_oc       = OPERATION_CODE_WIDTH'(3'b011);
            w_acc_next = alu_result_i;
          end
          OP_JMP: w_pc_next = w_imm;
          OP_JC:  if (r_carry) w_pc_next = w_imm;
          OP_JZ:  if (r_acc == '0) w_pc_next = w_imm;
          OP_OUT: w_out_load = 1'b1;
          OP_HLT: begin
            w_state_next = S_HALT;
            w_pc_next    = r_pc;
          end
          default: ;
        endcase
      end
      S_HALT: w_state_next = S_HALT;
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
      S_WAIT: if (step_i) w_state_next = S_FETCH;
`endif
      default: w_state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_acc       <= w_acc_next;
      r_carry     <= w_carry_next;
      r_out_valid <= w_out_load;
      if (r_state == S_DECODE) r_ir <= instr_data_i;
      if (w_out_load) r_out <= r_acc;
    end
  end

  assign instr_addr_o = r_pc;
  assign alu_a_o      = r_acc;
  assign alu_b_o      = w_imm;
  assign alu_oc_o     = w_oc;
  assign acc_o        = r_acc;
  assign carry_o      = r_carry;
  assign halt_o       = (r_state == S_HALT);
  assign out_o        = r_out;
  assign out_valid_o  = r_out_valid;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a combinational program ROM and a 4-bit ALU model.
module tb_control_unit;
  logic       clk;
  logic       rst_i;
  logic [3:0] instr_addr_o;
  logic [7:0] instr_data_i;
  logic [3:0] alu_a_o;
  logic [3:0] alu_b_o;
  logic [2:0] alu_oc_o;
  logic [3:0] alu_result_i;
  logic       alu_carry_i;
  logic [3:0] acc_o;
  logic       carry_o;
  logic       halt_o;
  logic [3:0] out_o;
  logic       out_valid_o;
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
  logic       step_i;
  initial step_i = 1'b1;
`endif

  logic [7:0] mem [16];
  int n_assert;
  int n_fail;

  control_unit #(.ALU_BIT_WIDTH(4), .OPERATION_CODE_WIDTH(3)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
    .step_i       (step_i),
`endif
    .instr_addr_o (instr_addr_o),
    .instr_data_i (instr_data_i),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_oc_o     (alu_oc_o),
    .alu_result_i (alu_result_i),
    .alu_carry_i  (alu_carry_i),
    .acc_o        (acc_o),
    .carry_o      (carry_o),
    .halt_o       (halt_o),
    .out_o        (out_o),
    .out_valid_o  (out_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Address is stable through FETCH and DECODE, so a combinational ROM suffices.
  assign instr_data_i = mem[instr_addr_o];

  // Logic ops report carry=1 so that any wrongful carry load is visible.
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    case (alu_oc_o)
      3'b100:  alu_sum = {1'b0, alu_a_o} + {1'b0, alu_b_o};
      3'b110:  alu_sum = {1'b0, alu_a_o} + {1'b0, ~alu_b_o} + 5'd1;
      3'b001:  alu_sum = {1'b1, alu_a_o ^ alu_b_o};
      3'b010:  alu_sum = {1'b1, alu_a_o & alu_b_o};
      3'b011:  alu_sum = {1'b1, alu_a_o | alu_b_o};
      default: alu_sum = 5'h10;
    endcase
  end
  assign alu_result_i = alu_sum[3:0];
  assign alu_carry_i  = alu_sum[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  // Returns at the negedge of cycle 0 (first FETCH after reset).
  task automatic do_reset();
    rst_i = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_i    = 1'b1;

    // LDI 5, ADDI 3, OUT
    clear_mem();
    mem[0] = 8'h15; mem[1] = 8'h23; mem[2] = 8'hA0;
    do_reset();
    check("rst_addr", instr_addr_o, 4'h0);
    check("rst_acc", acc_o, 4'h0);
    check("rst_carry", carry_o, 1'b0);
    check("rst_halt", halt_o, 1'b0);
    check("rst_out", out_o, 4'h0);
    check("rst_outv", out_valid_o, 1'b0);
    check("rst_oc", alu_oc_o, 3'b000);
    step(4);
    check("dec_oc_zero", alu_oc_o, 3'b000);
    step(1);
    check("addi_oc", alu_oc_o, 3'b100);
    check("addi_a", alu_a_o, 4'h5);
    check("addi_b", alu_b_o, 4'h3);
    step(3);
    check("outv_c8", out_valid_o, 1'b0);
    step(1);
    check("outv_c9", out_valid_o, 1'b1);
    check("out_c9", out_o, 4'h8);
    check("carry_c9", carry_o, 1'b0);
    step(1);
    check("outv_c10", out_valid_o, 1'b0);
    check("out_hold", out_o, 4'h8);

    // LDI F, ADDI 1, JC 7
    clear_mem();
    mem[0] = 8'h1F; mem[1] = 8'h21; mem[2] = 8'h87;
    do_reset();
    step(9);
    check("jc_acc", acc_o, 4'h0);
    check("jc_carry", carry_o, 1'b1);
    check("jc_addr", instr_addr_o, 4'h7);

    // LDI 3, SUBI 5
    clear_mem();
    mem[0] = 8'h13; mem[1] = 8'h35;
    do_reset();
    step(5);
    check("subi_oc", alu_oc_o, 3'b110);
    step(1);
    check("sub_borrow_acc", acc_o, 4'hE);
    check("sub_borrow_carry", carry_o, 1'b0);

    // LDI 5, SUBI 3
    clear_mem();
    mem[0] = 8'h15; mem[1] = 8'h33;
    do_reset();
    step(6);
    check("sub_ok_acc", acc_o, 4'h2);
    check("sub_ok_carry", carry_o, 1'b1);

    // Logic ops, JZ not-taken / taken, NOP opcode
    clear_mem();
    mem[0] = 8'h16; mem[1] = 8'h43; mem[2] = 8'h5C; mem[3] = 8'h61;
    mem[4] = 8'h99; mem[5] = 8'h45; mem[6] = 8'h9C; mem[12] = 8'hB7;
    do_reset();
    step(5);
    check("xori_oc", alu_oc_o, 3'b001);
    step(1);
    check("xori_acc", acc_o, 4'h5);
    step(2);
    check("andi_oc", alu_oc_o, 3'b010);
    step(1);
    check("andi_acc", acc_o, 4'h4);
    step(2);
    check("ori_oc", alu_oc_o, 3'b011);
    step(1);
    check("ori_acc", acc_o, 4'h5);
    check("logic_carry", carry_o, 1'b0);
    step(3);
    check("jz_not_taken", instr_addr_o, 4'h5);
    step(3);
    check("xor_zero", acc_o, 4'h0);
    step(3);
    check("jz_taken", instr_addr_o, 4'hC);
    step(2);
    check("nop_oc", alu_oc_o, 3'b000);
    step(1);
    check("nop_acc", acc_o, 4'h0);
    check("nop_pc", instr_addr_o, 4'hD);

    // JMP F, NOP at F -> wrap
    clear_mem();
    mem[0] = 8'h7F; mem[15] = 8'h00;
    do_reset();
    step(3);
    check("jmp_addr", instr_addr_o, 4'hF);
    step(3);
    check("wrap_addr", instr_addr_o, 4'h0);

    // NOP, NOP, HLT
    clear_mem();
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2] = 8'hF0;
    do_reset();
    step(8);
    check("halt_c8", halt_o, 1'b0);
    step(1);
    check("halt_c9", halt_o, 1'b1);
    check("halt_addr_c9", instr_addr_o, 4'h2);
    for (int k = 0; k < 4; k++) begin
      step(5);
      check("halt_hold", halt_o, 1'b1);
      check("halt_addr_hold", instr_addr_o, 4'h2);
    end
    do_reset();
    check("halt_rst_addr", instr_addr_o, 4'h0);
    check("halt_rst_halt", halt_o, 1'b0);

    // Reset during EXECUTE of ADDI 3 after LDI 1
    clear_mem();
    mem[0] = 8'h11; mem[1] = 8'h23;
    do_reset();
    step(4);
    check("pre_rst_acc", acc_o, 4'h1);
    step(1);
    check("mid_exec_oc", alu_oc_o, 3'b100);
    rst_i = 1'b1;
    step(1);
    rst_i = 1'b0;
    check("mid_rst_acc", acc_o, 4'h0);
    check("mid_rst_addr", instr_addr_o, 4'h0);
    check("mid_rst_carry", carry_o, 1'b0);
    step(3);
    check("mid_rst_refetch_acc", acc_o, 4'h1);
    check("mid_rst_refetch_addr", instr_addr_o, 4'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
